alu_multicycle: RTL

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_muldiv_iter.sv | 83 ++++++++
 rtl/alu_multicycle.sv | 94 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes used by the ALU control stage and the
// multicycle ALU's FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_DIV = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_valid_ctrl(input logic [3:0] ctrl);
    return ctrl inside {ALU_AND, ALU_DIV, ALU_ADD, ALU_MUL, ALU_SUB, ALU_SLT};
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative datapath: shift-add multiply or restoring divide on magnitudes,
// one bit per step, XLEN steps per operation.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            clear,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);

  // acc: product accumulator / partial remainder; x: multiplicand / dividend
  // shifting into quotient; y: multiplier / divisor magnitude.
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc, x, y;
  logic            div_mode, neg;

  logic [XLEN-1:0] mul_acc_nx, div_rem_nx, div_quo_nx;
  logic [XLEN:0]   rem_sh, rem_sub;
  logic            q_bit;

  always_comb begin
    mul_acc_nx = acc + (y[0] ? x : '0);
    rem_sh     = {acc, x[XLEN-1]};
    rem_sub    = rem_sh - {1'b0, y};
    q_bit      = ~rem_sub[XLEN];
    div_rem_nx = q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
    div_quo_nx = {x[XLEN-2:0], q_bit};
  end

  // The quotient sign is applied only on the value handed to the output register.
  assign res  = div_mode ? (neg ? (~div_quo_nx + 1'b1) : div_quo_nx) : mul_acc_nx;
  assign last = (cnt == CW'(XLEN - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      x        <= '0;
      y        <= '0;
      div_mode <= 1'b0;
      neg      <= 1'b0;
    end else if (load) begin
      cnt      <= '0;
      acc      <= '0;
      div_mode <= is_div;
      if (is_div) begin
        x   <= a[XLEN-1] ? (~a + 1'b1) : a;
        y   <= b[XLEN-1] ? (~b + 1'b1) : b;
        neg <= a[XLEN-1] ^ b[XLEN-1];
      end else begin
        x   <= a;
        y   <= b;
        neg <= 1'b0;
      end
    end else if (clear) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (div_mode) begin
        acc <= div_rem_nx;
        x   <= div_quo_nx;
      end else begin
        acc <= mul_acc_nx;
        x   <= x << 1;
        y   <= y >> 1;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle AND/ADD/SUB/SLT, XLEN-iteration MUL/DIV, with a
// registered result and a one-cycle done pulse. Kill flushes an in-flight op.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            done,
  output logic            busy,
  output logic            err
);

  state_t          state;
  logic            accept, go_iter, invalid, md_last;
  logic [XLEN-1:0] single_res, md_res;

  assign accept  = (state == IDLE) && start && !kill;
  assign go_iter = (alu_ctrl == ALU_MUL) || ((alu_ctrl == ALU_DIV) && (op_b != '0));
  assign invalid = !is_valid_ctrl(alu_ctrl);

  // NOTE: defaulting every output first keeps this block free of inferred latches.
  always_comb begin
    single_res = '0;
    case (alu_ctrl)
      ALU_AND: single_res = op_a & op_b;
      ALU_ADD: single_res = op_a + op_b;
      ALU_SUB: single_res = op_a - op_b;
      ALU_SLT: single_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_DIV: single_res = '1;  // only reached for a zero divisor
      default: single_res = '0;
    endcase
  end

  alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (accept && go_iter),
    .step   ((state == ITER) && !kill),
    .clear  (kill),
    .is_div (alu_ctrl == ALU_DIV),
    .a      (op_a),
    .b      (op_b),
    .last   (md_last),
    .res    (md_res)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE) && !kill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      zero   <= 1'b1;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (go_iter) begin
              state <= ITER;
            end else begin
              state  <= DONE;
              result <= single_res;
              zero   <= (single_res == '0);
              err    <= invalid;
            end
          end
        end
        ITER: begin
          if (kill) begin
            state <= IDLE;
          end else if (md_last) begin
            state  <= DONE;
            result <= md_res;
            zero   <= (md_res == '0);
            err    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
